// File: rtl/bch_pkg.sv
// Shared constants, FSM state encoding and a long-division reference model
// for the systematic BCH stream encoder family.
package bch_pkg;

  localparam int BCH_N = 31;
  localparam int BCH_K = 20;
  localparam int BCH_R = BCH_N - BCH_K;

  // g(x) = x^10 + x^9 + x^8 + x^5 + x + 1
  localparam logic [10:0] BCH_GEN = 11'b11100100011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bch_enc_state_t;

  // Degree of the default generator (index of its highest set coefficient).
  function automatic int bch_gen_degree();
    int d;
    d = 0;
    for (int i = 0; i < 11; i++) begin
      if (BCH_GEN[i]) d = i;
      else            d = d;
    end
    return d;
  endfunction

  // Remainder of a codeword-wide polynomial modulo g(x) by plain long division.
  function automatic logic [BCH_R-1:0] bch_remainder(input logic [BCH_N-1:0] poly);
    logic [BCH_N-1:0] rem;
    logic [BCH_N-1:0] g_w;
    int               deg;
    deg = bch_gen_degree();
    rem = poly;
    g_w = BCH_N'(BCH_GEN);
    for (int i = BCH_N - 1; i >= 0; i--) begin
      if ((i >= deg) && rem[i]) rem = rem ^ (g_w << (i - deg));
      else                      rem = rem;
    end
    return rem[BCH_R-1:0];
  endfunction

  // Systematic parity for the default code: (msg * x^R) mod g(x).
  function automatic logic [BCH_R-1:0] bch_parity_ref(input logic [BCH_K-1:0] msg);
    return bch_remainder({msg, {BCH_R{1'b0}}});
  endfunction

endpackage

// File: rtl/bch_lfsr_step.sv
// One beat of the BCH remainder LFSR: folds P message bits (highest order
// first) into an R-bit remainder.  Each bit performs r <- (r*x + b*x^R) mod g.
// The generator may have degree D <= R; when D == R this is the classic
// fb = b ^ r[R-1] feedback register, and for D < R the parity field simply
// carries R-D leading zero coefficients.
module bch_lfsr_step
  import bch_pkg::*;
#(
  parameter int         R   = BCH_R,
  parameter int         P   = 4,
  parameter logic [R:0] GEN = (R + 1)'(BCH_GEN)
) (
  input  logic [R-1:0] state_in,
  input  logic [P-1:0] bits_in,
  output logic [R-1:0] state_out
);

  // Degree of the generator actually supplied.
  function automatic int gen_degree();
    int d;
    d = 0;
    for (int i = 0; i <= R; i++) begin
      if (GEN[i]) d = i;
      else        d = d;
    end
    return d;
  endfunction

  localparam int D = gen_degree();

  // x^R mod g(x): the contribution of a single message bit entering the register.
  function automatic logic [R-1:0] x_pow_r_mod_g();
    logic [R:0] t;
    t    = '0;
    t[0] = 1'b1;
    for (int i = 0; i < R; i++) begin
      t = t << 1;
      if (t[D]) t = t ^ GEN;
      else      t = t;
    end
    return t[R-1:0];
  endfunction

  localparam logic [R-1:0] XR = x_pow_r_mod_g();

  logic [R-1:0] acc_s;
  logic         fb_s;

  // Fold the beat's bits into the remainder, highest-order bit first.
  always_comb begin
    acc_s = state_in;
    fb_s  = 1'b0;
    for (int i = P - 1; i >= 0; i--) begin
      fb_s  = acc_s[D-1];
      acc_s = (acc_s << 1)
            ^ (fb_s       ? GEN[R-1:0] : {R{1'b0}})
            ^ (bits_in[i] ? XR         : {R{1'b0}});
    end
    state_out = acc_s;
  end

endmodule

// File: rtl/bch_stream_encoder.sv
// Sequential systematic BCH encoder with valid/ready on both sides.
// A message is captured in IDLE (or in DONE on the same edge the previous
// codeword is taken), its parity is built over K/P beats in SHIFT, and the
// codeword {msg, parity} is held in DONE until the output handshake.
module bch_stream_encoder
  import bch_pkg::*;
#(
  parameter int             N   = BCH_N,
  parameter int             K   = BCH_K,
  parameter logic [N-K:0]   GEN = (N - K + 1)'(BCH_GEN),
  parameter int             P   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_msg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_codeword,
  output logic         busy
);

  localparam int R     = N - K;
  localparam int BEATS = K / P;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_DONE  = DONE;

  // Elaboration-time parameter legality.
  if (N <= K) begin : g_chk_nk
    $error("bch_stream_encoder: N must exceed K");
  end
  if ((P < 1) || (P > K) || ((K % P) != 0)) begin : g_chk_p
    $error("bch_stream_encoder: P must divide K with 1 <= P <= K");
  end
  if ((GEN[0] != 1'b1) || (GEN[N-K:1] == '0)) begin : g_chk_gen
    $error("bch_stream_encoder: generator needs a constant term and degree >= 1");
  end

  logic [1:0]       state_q, state_d;
  logic [K-1:0]     msg_q,   msg_d;
  logic [R-1:0]     lfsr_q,  lfsr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             live_q;

  logic [P-1:0]     beat_bits_s;
  logic [R-1:0]     step_s;
  logic             accept_s;

  // Next P unprocessed message bits, highest order first.
  assign beat_bits_s = msg_q[(K - 1) - (int'(cnt_q) * P) -: P];

  bch_lfsr_step #(
    .R   (R),
    .P   (P),
    .GEN (GEN)
  ) u_step (
    .state_in  (lfsr_q),
    .bits_in   (beat_bits_s),
    .state_out (step_s)
  );

  // live_q keeps in_ready low until the first clock after reset release;
  // in DONE the ready is a pass-through of out_ready for back-to-back accepts.
  assign in_ready = live_q & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept_s = in_valid & in_ready;

  assign out_valid    = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign out_codeword = {msg_q, lfsr_q};

  // FSM and datapath next-state: capture, per-beat LFSR update, hold for handshake.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          msg_d   = in_msg;
          lfsr_d  = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        lfsr_d = step_s;
        if (cnt_q == LAST_BEAT) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (accept_s) begin
          msg_d   = in_msg;
          lfsr_d  = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        msg_d   = '0;
        lfsr_d  = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      msg_q   <= '0;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bch_stream_encoder.sv
// Self-checking bench for bch_stream_encoder: directed vectors on a P=4
// instance, plus a randomised handshake sweep across several parallelisms.
module tb_bch_stream_encoder;
  import bch_pkg::*;

  localparam int NP   = 6;
  localparam int PV [NP] = '{1, 2, 4, 5, 10, 20};
  localparam int SW_N = 340;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_msg;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] out_codeword;
  logic        busy;

  int n_checks;
  int n_fail;

  logic [30:0] exp_q [$];

  logic        sw_in_valid  [NP];
  logic        sw_in_ready  [NP];
  logic [19:0] sw_in_msg    [NP];
  logic        sw_out_valid [NP];
  logic        sw_out_ready [NP];
  logic [30:0] sw_cw        [NP];
  logic        sw_busy      [NP];
  logic [30:0] sw_q [NP][$];

  bch_stream_encoder #(.P(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_msg       (in_msg),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_codeword (out_codeword),
    .busy         (busy)
  );

  for (genvar g = 0; g < NP; g++) begin : g_sweep
    bch_stream_encoder #(.P(PV[g])) u_enc (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (sw_in_valid[g]),
      .in_ready     (sw_in_ready[g]),
      .in_msg       (sw_in_msg[g]),
      .out_valid    (sw_out_valid[g]),
      .out_ready    (sw_out_ready[g]),
      .out_codeword (sw_cw[g]),
      .busy         (sw_busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a message until it is taken; records the expected codeword.
  task automatic accept_msg(input logic [19:0] m, output bit ok);
    int guard;
    guard    = 0;
    in_msg   = m;
    in_valid = 1'b1;
    #1;
    while ((in_ready !== 1'b1) && (guard < 100)) begin
      step();
      guard++;
    end
    ok = (in_ready === 1'b1);
    if (ok) exp_q.push_back({m, bch_parity_ref(m)});
    step();
    in_valid = 1'b0;
    in_msg   = 20'($urandom());
  endtask

  // Edges after the accept edge until out_valid rises, -1 on timeout.
  task automatic wait_out(output int edges);
    edges = 0;
    while ((out_valid !== 1'b1) && (edges < 100)) begin
      step();
      edges++;
    end
    if (out_valid !== 1'b1) edges = -1;
  endtask

  task automatic test_reset();
    bit          ok;
    int          edges;
    int          seen;
    logic [30:0] exp_cw;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_codeword !== 31'h0) begin n_fail++; $display("FAIL reset_codeword: got %h want 0", out_codeword); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    step();
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_hold_in_ready: got %b want 0", in_ready); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready_pre: got %b want 0", in_ready); end
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready_post: got %b want 1", in_ready); end

    accept_msg(20'hABCDE, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midshift_accept: got %b want 1", ok); end
    step();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midshift_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midshift_rst_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midshift_rst_busy: got %b want 0", busy); end
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midshift_no_output: got %0d valid cycles want 0", seen); end

    accept_msg(20'h00000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL zero_accept: got %b want 1", ok); end
    wait_out(edges);
    n_checks++; if (edges + 1 !== 6) begin n_fail++; $display("FAIL zero_latency: got %0d edges want 6", edges + 1); end
    n_checks++; if (out_codeword !== 31'h0000_0000) begin n_fail++; $display("FAIL zero_codeword: got %h want 00000000", out_codeword); end
    if (exp_q.size() == 0) exp_cw = 'x; else exp_cw = exp_q.pop_front();
    n_checks++; if (out_codeword !== exp_cw) begin n_fail++; $display("FAIL zero_model: got %h want %h", out_codeword, exp_cw); end
    step();
  endtask

  task automatic test_single_bit();
    bit          ok;
    int          edges;
    logic [30:0] exp_cw;
    accept_msg(20'h00001, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b want 1", ok); end
    wait_out(edges);
    n_checks++; if (edges + 1 !== 6) begin n_fail++; $display("FAIL single_latency: got %0d edges want 6", edges + 1); end
    n_checks++; if (out_codeword !== 31'h0000_0965) begin n_fail++; $display("FAIL single_codeword: got %h want 00000965", out_codeword); end
    if (exp_q.size() == 0) exp_cw = 'x; else exp_cw = exp_q.pop_front();
    n_checks++; if (out_codeword !== exp_cw) begin n_fail++; $display("FAIL single_model: got %h want %h", out_codeword, exp_cw); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_after_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_after_busy: got %b want 0", busy); end
  endtask

  task automatic test_linearity();
    bit          ok;
    int          edges;
    logic [30:0] exp_cw;
    accept_msg(20'h00003, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL lin_accept: got %b want 1", ok); end
    wait_out(edges);
    n_checks++; if (edges < 0) begin n_fail++; $display("FAIL lin_timeout: got %0d want >=0", edges); end
    n_checks++; if (out_codeword !== 31'h0000_1BAF) begin n_fail++; $display("FAIL lin_codeword: got %h want 00001baf", out_codeword); end
    if (exp_q.size() == 0) exp_cw = 'x; else exp_cw = exp_q.pop_front();
    n_checks++; if (out_codeword !== exp_cw) begin n_fail++; $display("FAIL lin_model: got %h want %h", out_codeword, exp_cw); end
    step();
  endtask

  task automatic test_back_pressure();
    bit          ok;
    int          edges;
    logic [30:0] exp_cw;
    out_ready = 1'b0;
    accept_msg(20'h00001, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got %b want 1", ok); end
    wait_out(edges);
    if (exp_q.size() == 0) exp_cw = 'x; else exp_cw = exp_q.pop_front();
    n_checks++; if (out_codeword !== exp_cw) begin n_fail++; $display("FAIL bp_model: got %h want %h", out_codeword, exp_cw); end
    in_msg   = 20'h00003;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
      n_checks++; if (out_codeword !== 31'h0000_0965) begin n_fail++; $display("FAIL bp_hold_cw[%0d]: got %h want 00000965", i, out_codeword); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, in_ready); end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_passthrough: got %b want 1", in_ready); end
    exp_q.push_back({20'h00003, bch_parity_ref(20'h00003)});
    step();
    in_valid = 1'b0;
    in_msg   = 20'($urandom());
    wait_out(edges);
    n_checks++; if (edges !== 5) begin n_fail++; $display("FAIL bp_b2b_latency: got %0d edges want 5", edges); end
    n_checks++; if (out_codeword !== 31'h0000_1BAF) begin n_fail++; $display("FAIL bp_b2b_cw: got %h want 00001baf", out_codeword); end
    if (exp_q.size() == 0) exp_cw = 'x; else exp_cw = exp_q.pop_front();
    n_checks++; if (out_codeword !== exp_cw) begin n_fail++; $display("FAIL bp_b2b_model: got %h want %h", out_codeword, exp_cw); end
    step();
  endtask

  task automatic test_streaming();
    logic [19:0] msgs [8];
    logic [30:0] exp_cw;
    int          sent;
    int          got;
    int          cyc;
    int          last;
    for (int i = 0; i < 8; i++) msgs[i] = 20'($urandom());
    out_ready = 1'b1;
    sent      = 0;
    got       = 0;
    cyc       = 0;
    last      = -1;
    in_msg    = msgs[0];
    in_valid  = 1'b1;
    #1;
    while ((got < 8) && (cyc < 300)) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) exp_cw = 'x; else exp_cw = exp_q.pop_front();
        n_checks++; if (out_codeword !== exp_cw) begin n_fail++; $display("FAIL stream_cw[%0d]: got %h want %h", got, out_codeword, exp_cw); end
        if (last >= 0) begin
          n_checks++; if (cyc - last !== 6) begin n_fail++; $display("FAIL stream_period[%0d]: got %0d want 6", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
      if ((in_valid === 1'b1) && (in_ready === 1'b1)) begin
        exp_q.push_back({in_msg, bch_parity_ref(in_msg)});
        sent++;
      end
      step();
      cyc++;
      if (sent < 8) in_msg = msgs[sent];
      else          in_valid = 1'b0;
    end
    n_checks++; if (got !== 8) begin n_fail++; $display("FAIL stream_count: got %0d want 8", got); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stream_leftover: got %0d want 0", exp_q.size()); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random_sweep();
    int          sent [NP];
    int          got  [NP];
    bit          acc  [NP];
    int          cyc;
    bit          all_done;
    logic [30:0] exp_cw;
    for (int i = 0; i < NP; i++) begin
      sent[i] = 0;
      got[i]  = 0;
      acc[i]  = 1'b0;
      sw_q[i].delete();
    end
    cyc      = 0;
    all_done = 1'b0;
    while (!all_done && (cyc < 40000)) begin
      for (int i = 0; i < NP; i++) begin
        sw_out_ready[i] = ($urandom_range(0, 3) != 0);
        if (!sw_in_valid[i] && (sent[i] < SW_N) && ($urandom_range(0, 2) != 0)) begin
          sw_in_valid[i] = 1'b1;
          sw_in_msg[i]   = 20'($urandom());
        end
      end
      #1;
      for (int i = 0; i < NP; i++) begin
        acc[i] = 1'b0;
        if (sw_out_valid[i] && sw_out_ready[i]) begin
          if (sw_q[i].size() == 0) exp_cw = 'x; else exp_cw = sw_q[i].pop_front();
          n_checks++; if (sw_cw[i] !== exp_cw) begin n_fail++; $display("FAIL sweep_cw P=%0d #%0d: got %h want %h", PV[i], got[i], sw_cw[i], exp_cw); end
          n_checks++; if (bch_remainder(sw_cw[i]) !== 11'h0) begin n_fail++; $display("FAIL sweep_syndrome P=%0d #%0d: got %h want 0", PV[i], got[i], bch_remainder(sw_cw[i])); end
          n_checks++; if (sw_busy[i] !== 1'b1) begin n_fail++; $display("FAIL sweep_busy P=%0d: got %b want 1", PV[i], sw_busy[i]); end
          got[i]++;
        end
        if (sw_in_valid[i] && sw_in_ready[i]) begin
          sw_q[i].push_back({sw_in_msg[i], bch_parity_ref(sw_in_msg[i])});
          sent[i]++;
          acc[i] = 1'b1;
        end
      end
      step();
      cyc++;
      all_done = 1'b1;
      for (int i = 0; i < NP; i++) begin
        if (acc[i]) begin
          sw_in_valid[i] = 1'b0;
          sw_in_msg[i]   = 20'($urandom());
        end
        if (got[i] < SW_N) all_done = 1'b0;
      end
    end
    for (int i = 0; i < NP; i++) begin
      n_checks++; if (got[i] !== SW_N) begin n_fail++; $display("FAIL sweep_count P=%0d: got %0d want %0d", PV[i], got[i], SW_N); end
      n_checks++; if (sw_q[i].size() !== 0) begin n_fail++; $display("FAIL sweep_leftover P=%0d: got %0d want 0", PV[i], sw_q[i].size()); end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_msg    = 20'h0;
    out_ready = 1'b1;
    for (int i = 0; i < NP; i++) begin
      sw_in_valid[i]  = 1'b0;
      sw_in_msg[i]    = 20'h0;
      sw_out_ready[i] = 1'b0;
    end
    test_reset();
    test_single_bit();
    test_linearity();
    test_back_pressure();
    test_streaming();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
